// File: rtl/vga_timing_param.sv
// vga_timing_param: parametrised raster timing generator.
//
// A horizontal counter h (0..H_TOTAL-1) and a vertical counter v
// (0..V_TOTAL-1) advance on every clock that has i_Enable high. Every output
// is registered and decoded from the counter values held before the edge, so
// the outputs lag the counters by one enabled clock.
//
// Ports
//   i_Clk         pixel clock
//   i_Reset       synchronous reset, active-high, has priority over i_Enable
//   i_Enable      pixel clock enable; counters and outputs hold while low
//   o_HSync       horizontal sync, at H_POL level while asserted
//   o_VSync       vertical sync, at V_POL level while asserted
//   o_DE          data enable, high inside the active area
//   o_X / o_Y     active-area column / line, 0 outside the active area
//   o_LineStart   strobe for the first clock of each line
//   o_FrameStart  strobe for the first clock of each frame
module vga_timing_param #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter bit H_POL    = 1'b0,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter bit V_POL    = 1'b0,
    parameter int CTR_W    = 10
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Enable,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic             o_DE,
    output logic [CTR_W-1:0] o_X,
    output logic [CTR_W-1:0] o_Y,
    output logic             o_LineStart,
    output logic             o_FrameStart
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // Region bounds are kept as int: with a zero-length front porch the end
    // of the active area equals TOTAL, which need not fit in CTR_W bits.
    localparam int H_ACT_BEG = H_SYNC + H_BP;
    localparam int H_ACT_END = H_ACT_BEG + H_ACTIVE;
    localparam int V_ACT_BEG = V_SYNC + V_BP;
    localparam int V_ACT_END = V_ACT_BEG + V_ACTIVE;

    localparam logic [CTR_W-1:0] H_LAST    = CTR_W'(H_TOTAL - 1);
    localparam logic [CTR_W-1:0] V_LAST    = CTR_W'(V_TOTAL - 1);
    localparam logic [CTR_W-1:0] H_ACT_OFS = CTR_W'(H_ACT_BEG);
    localparam logic [CTR_W-1:0] V_ACT_OFS = CTR_W'(V_ACT_BEG);

    logic [CTR_W-1:0] h_q, h_d;
    logic [CTR_W-1:0] v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CTR_W-1:0] x_q, x_d;
    logic [CTR_W-1:0] y_q, y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    logic h_in_sync, v_in_sync, h_in_act, v_in_act;

    always_comb begin
        h_in_sync = int'(h_q) < H_SYNC;
        v_in_sync = int'(v_q) < V_SYNC;
        h_in_act  = (int'(h_q) >= H_ACT_BEG) && (int'(h_q) < H_ACT_END);
        v_in_act  = (int'(v_q) >= V_ACT_BEG) && (int'(v_q) < V_ACT_END);
    end

    always_comb begin
        h_d           = h_q + 1'b1;
        v_d           = v_q;
        hsync_d       = h_in_sync ? H_POL : ~H_POL;
        vsync_d       = v_in_sync ? V_POL : ~V_POL;
        de_d          = h_in_act && v_in_act;
        x_d           = '0;
        y_d           = '0;
        line_start_d  = (h_q == '0);
        frame_start_d = (h_q == '0) && (v_q == '0);

        // Wrapping on equality keeps both counters inside their ranges.
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end

        if (de_d) begin
            x_d = h_q - H_ACT_OFS;
            y_d = v_q - V_ACT_OFS;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (i_Enable) begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_HSync      = hsync_q;
    assign o_VSync      = vsync_q;
    assign o_DE         = de_q;
    assign o_X          = x_q;
    assign o_Y          = y_q;
    assign o_LineStart  = line_start_q;
    assign o_FrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param in a small mode (zero-length horizontal front
// porch, positive HSync, negative VSync). The reference model only counts
// enabled edges since the last reset and derives the raster position with
// division and modulo, then decodes the regions straight from the mode
// description.
module tb_vga_timing_param;

    localparam int HS = 3, HB = 2, HA = 8, HF = 0;
    localparam int VS = 2, VB = 1, VA = 4, VF = 1;
    localparam bit HP = 1'b1, VP = 1'b0;
    localparam int W  = 5;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FRAME = HT * VT;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         hsync, vsync, de, ls, fs;
    logic [W-1:0] x, y;

    int n_cmp = 0;
    int n_err = 0;
    int edges = 0;   // enabled edges since the last reset

    vga_timing_param #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF), .H_POL(HP),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF), .V_POL(VP),
        .CTR_W(W)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
        .o_HSync(hsync), .o_VSync(vsync), .o_DE(de),
        .o_X(x), .o_Y(y),
        .o_LineStart(ls), .o_FrameStart(fs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (edges=%0d)", tag, obs, exp, edges);
        end
    endtask

    // One clock: drive inputs on the falling edge, advance the model at the
    // rising edge, compare shortly after it.
    task automatic step(input bit r, input bit e);
        int idx, h, v;
        bit ehs, evs, ede, els, efs;
        int ex, ey;
        @(negedge clk);
        rst = r;
        en  = e;
        @(posedge clk);
        if (r)      edges = 0;
        else if (e) edges++;
        #1;
        if (edges == 0) begin
            ehs = ~HP; evs = ~VP; ede = 0; ex = 0; ey = 0; els = 0; efs = 0;
        end else begin
            idx = edges - 1;
            h   = idx % HT;
            v   = (idx / HT) % VT;
            ehs = (h < HS) ? HP : ~HP;
            evs = (v < VS) ? VP : ~VP;
            ede = (h >= HS + HB) && (h < HS + HB + HA) &&
                  (v >= VS + VB) && (v < VS + VB + VA);
            ex  = ede ? h - (HS + HB) : 0;
            ey  = ede ? v - (VS + VB) : 0;
            els = (h == 0);
            efs = (h == 0) && (v == 0);
        end
        check("hsync", int'(hsync), int'(ehs));
        check("vsync", int'(vsync), int'(evs));
        check("de",    int'(de),    int'(ede));
        check("x",     int'(x),     ex);
        check("y",     int'(y),     ey);
        check("line_start",  int'(ls), int'(els));
        check("frame_start", int'(fs), int'(efs));
    endtask

    initial begin
        int n_fs, n_ls, n_de, n_hs, n_vsl, max_x, max_y;

        // Reset for a few clocks: outputs at reset values.
        repeat (3) step(1'b1, 1'b1);

        // Two frames with enable tied high, plus aggregate counts.
        n_fs = 0; n_ls = 0; n_de = 0; n_hs = 0; n_vsl = 0; max_x = 0; max_y = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 1'b1);
            n_fs  += int'(fs);
            n_ls  += int'(ls);
            n_de  += int'(de);
            n_hs  += int'(hsync == HP);
            n_vsl += int'(ls && (vsync == VP));
            if (de && int'(x) > max_x) max_x = int'(x);
            if (de && int'(y) > max_y) max_y = int'(y);
        end
        check("frame_strobes_2f", n_fs, 2);
        check("line_strobes_2f",  n_ls, 2 * VT);
        check("de_clocks_2f",     n_de, 2 * HA * VA);
        check("hsync_clocks_2f",  n_hs, 2 * HS * VT);
        check("vsync_lines_2f",   n_vsl, 2 * VS);
        check("last_x",           max_x, HA - 1);
        check("last_y",           max_y, VA - 1);

        // Enable at 50% duty for just over a frame: outputs hold while low.
        for (int i = 0; i < 2 * FRAME + 10; i++) step(1'b0, i[0]);

        // Random enable.
        for (int i = 0; i < 300; i++) step(1'b0, 1'($urandom_range(0, 1)));

        // Reset mid-frame for 3 clocks, then a full frame and a bit more.
        for (int i = 0; i < 57; i++) step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1);
        n_fs = 0;
        for (int i = 0; i < FRAME + 1; i++) begin
            step(1'b0, 1'b1);
            n_fs += int'(fs);
        end
        check("frame_strobes_after_reset", n_fs, 2);

        // Reset with enable low: reset values apply and hold until enable.
        for (int i = 0; i < 23; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1);

        // Random enable with occasional resets.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_param.md
Name: vga_timing_param

Overview:
- Parametrised raster timing generator; successor to the fixed 640x480 timing block.
- Generates HSync/VSync/DE for any mode via parameters, with configurable sync polarity.
- Adds pixel-clock enable, active-area X/Y coordinates, and line/frame start strobes.
- Sits between the pixel clock domain and the framebuffer/pattern readout and video output stages.

Parameters:
H_SYNC, 96, horizontal sync pulse length (clocks)
H_BP, 48, horizontal back porch
H_ACTIVE, 640, horizontal active pixels
H_FP, 16, horizontal front porch
H_POL, 0, HSync asserted level (0 = negative)
V_SYNC, 2, vertical sync length (lines)
V_BP, 33, vertical back porch
V_ACTIVE, 480, vertical active lines
V_FP, 10, vertical front porch
V_POL, 0, VSync asserted level
CTR_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
i_Clk  in  1  pixel clock
i_Reset  in  1  synchronous reset, active-high
i_Enable  in  1  pixel clock enable; counters and outputs update only when high
o_HSync  out  1  horizontal sync at H_POL level when asserted
o_VSync  out  1  vertical sync at V_POL level when asserted
o_DE  out  1  data enable, high in active area
o_X  out  CTR_W  active pixel column; 0 outside active area
o_Y  out  CTR_W  active line; 0 outside active area
o_LineStart  out  1  one-cycle strobe for the first clock of each line
o_FrameStart  out  1  one-cycle strobe for the first clock of each frame

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP. V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Internal counters: h in 0..H_TOTAL-1, v in 0..V_TOTAL-1.
- When i_Enable is high:
  - h increments each clock and wraps from H_TOTAL-1 to 0.
  - On that wrap, v increments and wraps from V_TOTAL-1 to 0.
- Region order per axis: sync [0,SYNC), back porch [SYNC,SYNC+BP), active [SYNC+BP,SYNC+BP+ACTIVE), front porch [rest].
- All outputs are registered and decoded from the current counter values. Latency is one enabled clock: outputs after edge n+1 reflect the counter state (h,v) present at edge n.
- Output decode:
  - o_HSync = H_POL while h is in sync, else !H_POL. VSync uses v in the same way.
  - o_DE = h active AND v active.
  - o_X = h-(H_SYNC+H_BP) while DE, else 0. o_Y = v-(V_SYNC+V_BP) while DE, else 0.
  - o_LineStart = 1 when h==0. o_FrameStart = 1 when h==0 and v==0.
- VSync changes only at line boundaries, coincident with the LineStart cycle.
- When i_Enable is low: counters and all outputs hold. Strobes hold too, so a strobe stays high across disabled cycles until the next enabled edge.
- Reset (any time, including mid-line or mid-frame; takes priority over i_Enable):
  - h=0, v=0.
  - o_HSync=!H_POL, o_VSync=!V_POL.
  - o_DE=0, o_X=0, o_Y=0, o_LineStart=0, o_FrameStart=0.
- First enabled clock after reset: outputs decode (0,0), so FrameStart=1, LineStart=1, HSync=H_POL, VSync=V_POL.
- No illegal states. Counters only ever take values in range, because they wrap on equality to TOTAL-1.
- Zero-length porches are legal; a region of length 0 is simply absent. SYNC and ACTIVE must be at least 1.

Test Plan:
- Default params, enable tied high, 2 frames -> per line: HSync low exactly 96 clocks, period 800, DE high 640 clocks. Per frame: VSync low 2 lines, period 525 lines, 480 DE lines.
- Default params, check coordinates -> first DE at counter (144,35) with o_X=0, o_Y=0. Last DE shows o_X=639, o_Y=479. o_X/o_Y are 0 whenever DE is low.
- Small mode H=2/1/4/1, V=1/1/3/1, H_POL=V_POL=1 -> line period 8, HSync high 2 clocks, DE 4 clocks/line on 3 lines, frame 48 clocks. FrameStart pulses every 48 clocks, LineStart every 8.
- i_Enable at 50% duty (alternate cycles) -> all output periods double in clocks. Outputs and strobes are stable across disabled cycles. Sequences are identical to the enabled-only trace.
- Reset asserted at h=300, v=200 for 3 clocks -> outputs take reset values the clock after assertion. After release, FrameStart on the first enabled clock, then a full-length frame follows.
- Reset asserted together with i_Enable=0 -> reset values still applied; output holds them until enable resumes.
